// File: rtl/vga_pixel_sink_if.sv
// Pixel stream and framebuffer write port bundle for vga_pixel_sink.
// master = drawing side / RAM model, slave = the sink.
interface vga_pixel_sink_if #(
  parameter int COLOUR_W = 3,
  parameter int ADDR_W   = 15
);
  logic                plot;
  logic [7:0]          x_in;
  logic [6:0]          y_in;
  logic [COLOUR_W-1:0] colour_in;
  logic                ready;
  logic [ADDR_W-1:0]   mem_address;
  logic [COLOUR_W-1:0] mem_data;
  logic                mem_wren;
  logic                mem_ready;

  modport master (
    output plot, x_in, y_in, colour_in, mem_ready,
    input  ready, mem_address, mem_data, mem_wren
  );

  modport slave (
    input  plot, x_in, y_in, colour_in, mem_ready,
    output ready, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/vga_pixel_sink.sv
// Pixel stream sink: range check, address calc, FIFO, framebuffer write.
// Counts written pixels and flags a completed frame.
module vga_pixel_sink #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int COLOUR_W   = 3,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear_count,
  vga_pixel_sink_if.slave   px,
  output logic [ADDR_W-1:0] pixel_count,
  output logic              frame_done,
  output logic              dropped
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] FULL = ADDR_W'(WIDTH * HEIGHT);

  logic                s1_valid;
  logic [7:0]          s1_x;
  logic [6:0]          s1_y;
  logic [COLOUR_W-1:0] s1_c;
  logic                s2_valid;
  logic [ADDR_W-1:0]   s2_addr;
  logic [COLOUR_W-1:0] s2_c;

  logic [ADDR_W-1:0]   f_addr [FIFO_DEPTH];
  logic [COLOUR_W-1:0] f_col  [FIFO_DEPTH];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [CW-1:0]       count;
  logic [CW:0]         occ;

  logic accept;
  logic in_range;
  logic push;
  logic pop;

  // Slots already claimed by pixels in flight count against space.
  assign occ = {1'b0, count}
             + (CW+1)'(s1_valid)
             + (CW+1)'(s2_valid);
  assign px.ready = resetn && (occ < (CW+1)'(FIFO_DEPTH));

  assign accept   = px.plot && px.ready;
  assign in_range = (32'(px.x_in) < WIDTH)
                 && (32'(px.y_in) < HEIGHT);
  assign push     = s2_valid;
  assign pop      = px.mem_wren && px.mem_ready;

  assign px.mem_wren    = (count != '0);
  assign px.mem_address = px.mem_wren ? f_addr[rptr] : '0;
  assign px.mem_data    = px.mem_wren ? f_col[rptr]  : '0;
  assign frame_done     = (pixel_count == FULL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_c     <= '0;
      dropped  <= 1'b0;
    end else begin
      s1_valid <= accept && in_range;
      dropped  <= accept && !in_range;
      if (accept) begin
        s1_x <= px.x_in;
        s1_y <= px.y_in;
        s1_c <= px.colour_in;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_c     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr <= ADDR_W'(WIDTH) * ADDR_W'(s1_y)
                 + ADDR_W'(s1_x);
        s2_c    <= s1_c;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        f_addr[i] <= '0;
        f_col[i]  <= '0;
      end
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        f_addr[wptr] <= s2_addr;
        f_col[wptr]  <= s2_c;
        wptr         <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixel_count <= '0;
    end else if (clear_count) begin
      pixel_count <= '0;
    end else if (pop && (pixel_count != FULL)) begin
      pixel_count <= pixel_count + 1'b1;
    end
  end
endmodule
